// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS fetch stage.
//   WORD_W        : instruction / address width
//   PC_INC        : byte increment between sequential fetches
//   fetch_state_e : fetch controller states (ST_HALT exists only when
//                   FETCH_MISALIGN_TRAP_EN is defined)
//   iq_entry_t    : one instruction-queue entry {pc, word}
//   word_align    : clears the byte offset of an address
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ST_HALT  = 2'd2
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } iq_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- parameterised synchronous FIFO used by the fetch stage,
// both as the instruction queue ({pc, word}) and as the PC FIFO of
// outstanding memory requests (pc only).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (control only)
//   flush_i    : empties the FIFO; dominates push and pop
//   push_i     : write data_i at the tail
//   data_i     : entry to write
//   pop_i      : drop the head entry
//   data_o     : head entry (valid when !empty_o)
//   occ_o      : number of stored entries
//   full_o     : occ_o == DEPTH
//   empty_o    : occ_o == 0
module fetch_queue #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  occ_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign occ_o   = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle, so occupancy stays unchanged.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch -- fetch stage of the 32-bit MIPS pipeline.
// Owns the PC, issues word reads to instruction memory under a credit
// scheme that guarantees queue space for every response, buffers returned
// words in an in-order queue and hands them to decode with their PC.
// Redirects from execute flush the queue and discard in-flight responses.
//
// Build option: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect to a
// non word-aligned PC sets the sticky misalign_err and halts fetch until
// reset; when undefined, redirect_pc[1:0] is ignored and misalign_err is 0.
//
// Parameters:
//   RESET_PC    : first PC fetched after reset
//   QUEUE_DEPTH : queue entries and max outstanding requests (2..8)
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr : memory read request (addr == PC)
//   imem_rsp_valid, imem_rsp_data   : in-order read responses
//   redirect_valid, redirect_pc     : one-cycle PC change from execute
//   inst_valid/ready, instruction, inst_pc : instruction to decode
//   misalign_err                : sticky misaligned-redirect flag
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int IQ_W  = $bits(iq_entry_t);

  fetch_state_e        state_q, state_d;
  logic [WORD_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                iq_push, iq_pop, iq_full, iq_empty;
  iq_entry_t           iq_din, iq_head;
  logic [IQ_W-1:0]     iq_dout;
  logic [CNT_W-1:0]    iq_occ;

  logic                pf_push, pf_pop, pf_full, pf_empty;
  logic [WORD_W-1:0]   pf_dout;
  logic [CNT_W-1:0]    pf_occ;

  logic                redirect_eff;
  logic [WORD_W-1:0]   redir_target;
  logic                credit_ok;
  logic                req_fire;
  int                  drop_new;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
  logic                redir_misaligned;

  // Once halted, further redirects are ignored until reset.
  assign redirect_eff     = redirect_valid && (state_q != ST_HALT);
  assign redir_target     = redirect_pc;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign misalign_err     = misalign_q;
`else
  assign redirect_eff     = redirect_valid;
  assign redir_target     = word_align(redirect_pc);
  assign misalign_err     = 1'b0;
`endif

  // Full flags are implied by the credit rule; they are not needed here.
  logic unused_flags;
  assign unused_flags = &{1'b0, iq_full, pf_full, pf_empty};

  // ---- request side --------------------------------------------------------
  // Outstanding requests and queued words together never exceed the queue
  // depth. A pop in the same cycle frees a slot, which is what lets a
  // 1-cycle memory sustain one instruction per cycle with depth 2.
  assign iq_pop = inst_valid && inst_ready;

  always_comb begin
    credit_ok = (int'(pf_occ) + int'(iq_occ) - int'(iq_pop)) < QUEUE_DEPTH;
  end

  // rst_n gates the request so nothing is issued while reset is held.
  assign imem_req_valid = rst_n && (state_q == ST_FETCH) && !redirect_eff && credit_ok;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // PC of every accepted request, consumed as its response returns.
  assign pf_push = req_fire;
  assign pf_pop  = imem_rsp_valid && (state_q == ST_FETCH);

  fetch_queue #(
    .DATA_W (WORD_W),
    .DEPTH  (QUEUE_DEPTH)
  ) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_eff),
    .push_i  (pf_push),
    .data_i  (pc_q),
    .pop_i   (pf_pop),
    .data_o  (pf_dout),
    .occ_o   (pf_occ),
    .full_o  (pf_full),
    .empty_o (pf_empty)
  );

  // ---- response / queue side -----------------------------------------------
  // Responses arriving with a redirect belong to the old path and are dropped.
  assign iq_push     = imem_rsp_valid && (state_q == ST_FETCH) && !redirect_eff;
  assign iq_din.pc   = pf_dout;
  assign iq_din.word = imem_rsp_data;

  fetch_queue #(
    .DATA_W (IQ_W),
    .DEPTH  (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_eff),
    .push_i  (iq_push),
    .data_i  (iq_din),
    .pop_i   (iq_pop),
    .data_o  (iq_dout),
    .occ_o   (iq_occ),
    .full_o  (iq_full),
    .empty_o (iq_empty)
  );

  // Head entry is shown only while valid so idle outputs read as zero.
  assign iq_head     = iq_entry_t'(iq_dout);
  assign inst_valid  = !iq_empty;
  assign instruction = inst_valid ? iq_head.word : '0;
  assign inst_pc     = inst_valid ? iq_head.pc   : '0;

  // ---- control FSM ---------------------------------------------------------
  // Everything still in flight at a redirect (requests of the current path
  // plus any not-yet-drained older ones) must be discarded, except a
  // response that lands in the redirect cycle itself.
  always_comb begin
    drop_new = int'(pf_occ) + int'(drop_cnt_q) - int'(imem_rsp_valid);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    if (redirect_eff) begin
      pc_d       = redir_target;
      drop_cnt_d = CNT_W'(drop_new);
      state_d    = (drop_new != 0) ? ST_DRAIN : ST_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
      // HALT never pushes, so leftover responses need no counting.
      if (redir_misaligned) begin
        misalign_d = 1'b1;
        drop_cnt_d = '0;
        state_d    = ST_HALT;
      end
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (req_fire) pc_d = pc_q + PC_INC;
        end
        ST_DRAIN: begin
          if (imem_rsp_valid) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
            if (drop_cnt_q == CNT_W'(1)) state_d = ST_FETCH;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HALT: begin
          state_d = ST_HALT;
        end
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the 32-bit MIPS processor. It owns the program counter, issues word reads to instruction memory and buffers the returned words in a small in-order queue. It presents one instruction per cycle, with its PC, to the decode stage that splits instructions into opcode, register and immediate fields. It accepts branch/jump redirects from execute and discards any responses already in flight for the old path.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- QUEUE_DEPTH, 2, instruction queue entries; also the max outstanding memory requests (legal: 2..8)
- clk  input  1  rising-edge clock
- rst_n  input  1  **synchronous, active-low reset**
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  32  byte address of request, always PC
- imem_rsp_valid  input  1  read data returned (in order, ≥1 cycle after acceptance)
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  one-cycle pulse, change PC
- redirect_pc  input  32  new PC
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- instruction  output  32  instruction word to decode
- inst_pc  output  32  PC of `instruction`
- misalign_err  output  1  sticky misaligned-redirect flag (macro only, tied 0 otherwise)

## Operation
- State machine with states FETCH and DRAIN (plus HALT, macro only).
- Credit rule: request issued when `outstanding + occupancy < QUEUE_DEPTH` in FETCH. Every response is then guaranteed queue space.
- Request handshake: PC advances by 4 only on `imem_req_valid && imem_req_ready`. `imem_addr` holds stable while a request is stalled. PC wraps 32'hFFFF_FFFC → 0.
- Response: written to the queue tail with its PC, taken from a PC FIFO of outstanding requests. `outstanding` decrements.
- Output: head of the queue. Pop on `inst_valid && inst_ready`. `instruction`/`inst_pc` hold stable while `inst_valid && !inst_ready`.
- Redirect (FETCH or DRAIN):
  - PC ← redirect_pc.
  - Queue flushed.
  - drop_cnt ← outstanding, minus any response arriving that same cycle.
  - No request issued that cycle.
  - Next state: DRAIN if drop_cnt ≠ 0, else FETCH.
- DRAIN: no requests issued. Every response decrements drop_cnt and is discarded. Go to FETCH when drop_cnt reaches 0.
- Simultaneous redirect and pop: the pop completes (decode owns that word), then the flush applies.
- Simultaneous push and pop on a full queue: legal only if the credit rule held. Occupancy is unchanged.

## Timing
- Reset values: imem_req_valid 0, imem_addr RESET_PC, inst_valid 0, instruction 0, inst_pc 0, misalign_err 0, state FETCH, counters 0.
- First request in the first cycle after rst_n deasserts.
- Response to output latency: 1 cycle (`inst_valid` rises the cycle after `imem_rsp_valid`).
- Memory with 1-cycle response and QUEUE_DEPTH=2 sustains one instruction per cycle.
- After a redirect with no outstanding requests, the new-PC request issues the next cycle.
- Reset mid-operation: all state returns to reset values. Stale responses after reset are not the block's concern; the memory is reset too.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0] ≠ 0 sets misalign_err (sticky until reset) and enters HALT.
  - HALT issues no requests and discards responses.
  - The queue contents before the redirect are still flushed.
- Undefined:
  - redirect_pc[1:0] is forced to 0.
  - misalign_err is tied 0.
  - No HALT state.

## Structure
- Shared package `mips_pkg`: word width, fetch state enum, PC increment constant 4.
- One sub-module: `fetch_queue`, a parameterised synchronous FIFO with entries {pc, word}.
  - Instantiated once for the instruction queue.
  - Instantiated again, pc-only, for the outstanding-request PC FIFO.
  - Provides flush, occupancy, full, empty.

## Test plan
- Reset with RESET_PC=32'h0040_0000, memory ready, 1-cycle response → requests 0x400000, 0x400004, 0x400008 on consecutive cycles; inst_valid from cycle 2, one instruction per cycle.
- inst_ready held 0 for 5 cycles → at most QUEUE_DEPTH requests outstanding plus queued; instruction/inst_pc stable; resumes in order with no loss.
- imem_req_ready low 3 cycles → imem_addr held at 0x400008, PC not advanced.
- Redirect to 0x00400100 with 2 requests outstanding (3-cycle memory) → 2 responses discarded in DRAIN; next delivered inst_pc = 0x400100.
- Redirect in the same cycle as a pop of PC 0x400004 → that word is consumed; next inst_pc = redirect_pc.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x00400102 → misalign_err=1, no further requests, inst_valid 0 until reset.
